// File: rtl/bp_pkg.sv
// Shared helpers for the branch history table: default parameters, the saturating
// counter step functions and the PC-to-index mapping.
package bp_pkg;

  localparam int LP_ENTRIES = 16;
  localparam int LP_CTR_W   = 2;
  localparam int LP_PC_W    = 32;
  localparam int LP_GHR_W   = 4;

  // Counters are carried in 4 bits (the widest CTR_W) and truncated by the caller.
  function automatic logic [3:0] sat_inc(input logic [3:0] i_v, input logic [3:0] i_max);
    logic [3:0] w_r;
    if (i_v >= i_max) begin
      w_r = i_max;
    end else begin
      w_r = i_v + 4'd1;
    end
    return w_r;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] i_v);
    logic [3:0] w_r;
    if (i_v == 4'd0) begin
      w_r = 4'd0;
    end else begin
      w_r = i_v - 4'd1;
    end
    return w_r;
  endfunction

  function automatic logic [9:0] idx(input logic [63:0] i_pc, input int i_idx_w);
    logic [63:0] w_sh;
    w_sh = (i_pc >> 2) & ((64'd1 << i_idx_w) - 64'd1);
    return w_sh[9:0];
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of saturating counters with one combinational read port (MSB only)
// and one saturating increment/decrement write port.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int                 ENTRIES  = LP_ENTRIES,
  parameter int                 CTR_W    = LP_CTR_W,
  parameter logic [CTR_W-1:0]   INIT_CTR = {CTR_W{1'b1}},
  parameter int                 IDX_W    = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_msb,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_inc
);

  localparam logic [CTR_W-1:0] LP_MAX = '1;

  logic [CTR_W-1:0] r_ctr [ENTRIES];
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_next;

  assign w_cur    = r_ctr[i_wr_idx];
  assign o_rd_msb = r_ctr[i_rd_idx][CTR_W-1];

  always_comb begin
    w_next = w_cur;
    if (i_wr_inc) begin
      w_next = CTR_W'(sat_inc(4'(w_cur), 4'(LP_MAX)));
    end else begin
      w_next = CTR_W'(sat_dec(4'(w_cur)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= INIT_CTR;
      end
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table predictor: bimodal PC-indexed counters, or gshare indexing
// when the BHT_GSHARE_EN macro is defined. Also keeps branch/mispredict statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int               ENTRIES  = LP_ENTRIES,
  parameter int               CTR_W    = LP_CTR_W,
  parameter logic [CTR_W-1:0] INIT_CTR = {CTR_W{1'b1}},
  parameter int               PC_W     = LP_PC_W,
  parameter int               GHR_W    = LP_GHR_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            predict_o,
  input  logic            update_i,
  input  logic [PC_W-1:0] update_pc_i,
  input  logic            taken_i,
  input  logic            pred_i,
  output logic            mispredict_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [GHR_W-1:0] w_ghr;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             r_mispredict;
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispredict_cnt;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  // Newest outcome enters at the LSB; the pre-shift value indexes this cycle's update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ghr <= '0;
    end else if (update_i) begin
      r_ghr <= GHR_W'({r_ghr, taken_i});
    end
  end

  assign w_ghr = r_ghr;
`else
  assign w_ghr = '0;
`endif

  assign w_rd_idx = IDX_W'(idx(64'(pc_i), IDX_W)) ^ IDX_W'(w_ghr);
  assign w_wr_idx = IDX_W'(idx(64'(update_pc_i), IDX_W)) ^ IDX_W'(w_ghr);

  sat_counter_table #(
    .ENTRIES  (ENTRIES),
    .CTR_W    (CTR_W),
    .INIT_CTR (INIT_CTR),
    .IDX_W    (IDX_W)
  ) u_table (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_rd_idx (w_rd_idx),
    .o_rd_msb (predict_o),
    .i_wr_en  (update_i),
    .i_wr_idx (w_wr_idx),
    .i_wr_inc (taken_i)
  );

  // Statistics counters wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mispredict     <= 1'b0;
      r_branch_cnt     <= 32'd0;
      r_mispredict_cnt <= 32'd0;
    end else begin
      r_mispredict <= update_i & (pred_i ^ taken_i);
      if (update_i) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
        if (pred_i ^ taken_i) begin
          r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
      end
    end
  end

  assign mispredict_o     = r_mispredict;
  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht (default bimodal build) against an
// array-of-integers reference model.
module tb_branch_predictor_bht;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        predict_o;
  logic        update_i = 1'b0;
  logic [31:0] update_pc_i = 32'd0;
  logic        taken_i = 1'b0;
  logic        pred_i = 1'b0;
  logic        mispredict_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int          n_checks = 0;
  int          n_fail = 0;

  int          m_ctr [16];
  int unsigned m_branch;
  int unsigned m_misp;
  logic        m_mis_o;

  branch_predictor_bht dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .predict_o        (predict_o),
    .update_i         (update_i),
    .update_pc_i      (update_pc_i),
    .taken_i          (taken_i),
    .pred_i           (pred_i),
    .mispredict_o     (mispredict_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
    return (m_ctr[slot(pc)] >= 2) ? 1'b1 : 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 3;
    m_branch = 0;
    m_misp   = 0;
    m_mis_o  = 1'b0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic tk, input logic pd);
    int s;
    s = slot(pc);
    if (tk) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
    else    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
    m_branch = m_branch + 1;
    if (tk != pd) m_misp = m_misp + 1;
    m_mis_o = (tk != pd);
  endfunction

  task automatic upd(input logic [31:0] pc, input logic tk, input logic pd);
    @(negedge clk_i);
    update_i = 1'b1; update_pc_i = pc; taken_i = tk; pred_i = pd;
    @(posedge clk_i);
    model_update(pc, tk, pd);
    #1;
    update_i = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_i = 1'b0; pc_i = 32'h0;
    #12;
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL reset_predict: got %b expected 1", predict_o); end
    n_checks++; if (branch_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_branch_cnt: got %0d expected 0", branch_cnt_o); end
    n_checks++; if (mispredict_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_misp_cnt: got %0d expected 0", mispredict_cnt_o); end
    n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b expected 0", mispredict_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_train_not_taken();
    pc_i = 32'h10;
    upd(32'h10, 1'b0, 1'b1);
    n_checks++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL nt1_mispredict: got %b expected 1", mispredict_o); end
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL nt1_predict: got %b expected 1", predict_o); end
    upd(32'h10, 1'b0, 1'b1);
    n_checks++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL nt2_mispredict: got %b expected 1", mispredict_o); end
    n_checks++; if (predict_o !== 1'b0) begin n_fail++; $display("FAIL nt2_predict: got %b expected 0", predict_o); end
    n_checks++; if (mispredict_cnt_o !== 32'd2) begin n_fail++; $display("FAIL nt2_misp_cnt: got %0d expected 2", mispredict_cnt_o); end
    n_checks++; if (branch_cnt_o !== 32'd2) begin n_fail++; $display("FAIL nt2_branch_cnt: got %0d expected 2", branch_cnt_o); end
  endtask

  task automatic test_saturate();
    upd(32'h10, 1'b0, 1'b0);
    n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL sat_correct_pred: got %b expected 0", mispredict_o); end
    for (int i = 0; i < 5; i++) begin
      upd(32'h10, 1'b1, exp_pred(32'h10));
      pc_i = 32'h10; #1;
      n_checks++; if (predict_o !== exp_pred(32'h10)) begin n_fail++; $display("FAIL sat_step%0d: got %b expected %b", i, predict_o, exp_pred(32'h10)); end
    end
    n_checks++; if (m_ctr[4] != 3 || predict_o !== 1'b1) begin n_fail++; $display("FAIL sat_final: got %b expected 1", predict_o); end
    upd(32'h10, 1'b0, 1'b1);
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL sat_one_down: got %b expected 1", predict_o); end
    pc_i = 32'h14; #1;
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL neighbour_0x14: got %b expected 1", predict_o); end
  endtask

  task automatic test_alias();
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b0, 1'b1);
    pc_i = 32'h0; #1;
    n_checks++; if (predict_o !== 1'b0) begin n_fail++; $display("FAIL alias_0x00: got %b expected 0", predict_o); end
    n_checks++; if (branch_cnt_o !== m_branch) begin n_fail++; $display("FAIL alias_branch_cnt: got %0d expected %0d", branch_cnt_o, m_branch); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk_i);
    pc_i = 32'h20; update_i = 1'b1; update_pc_i = 32'h20; taken_i = 1'b0; pred_i = 1'b1;
    #1;
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle_pre: got %b expected 1", predict_o); end
    @(posedge clk_i);
    model_update(32'h20, 1'b0, 1'b1);
    #1; update_i = 1'b0;
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle_post: got %b expected 1", predict_o); end
    upd(32'h20, 1'b0, 1'b1);
    n_checks++; if (predict_o !== 1'b0) begin n_fail++; $display("FAIL same_cycle_second: got %b expected 0", predict_o); end
  endtask

  task automatic test_random();
    logic u;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      u = ($urandom_range(0, 3) != 0);
      pc_i = $urandom; update_i = u; update_pc_i = $urandom;
      taken_i = $urandom_range(0, 1) == 1; pred_i = $urandom_range(0, 1) == 1;
      if (i % 4 == 0) update_pc_i = pc_i;
      #1;
      n_checks++; if (predict_o !== exp_pred(pc_i)) begin n_fail++; $display("FAIL rnd_predict[%0d]: got %b expected %b", i, predict_o, exp_pred(pc_i)); end
      @(posedge clk_i);
      if (u) model_update(update_pc_i, taken_i, pred_i);
      else   m_mis_o = 1'b0;
      #1;
      update_i = 1'b0;
      n_checks++; if (mispredict_o !== m_mis_o) begin n_fail++; $display("FAIL rnd_mispredict[%0d]: got %b expected %b", i, mispredict_o, m_mis_o); end
      n_checks++; if (branch_cnt_o !== m_branch) begin n_fail++; $display("FAIL rnd_branch_cnt[%0d]: got %0d expected %0d", i, branch_cnt_o, m_branch); end
      n_checks++; if (mispredict_cnt_o !== m_misp) begin n_fail++; $display("FAIL rnd_misp_cnt[%0d]: got %0d expected %0d", i, mispredict_cnt_o, m_misp); end
      n_checks++; if (predict_o !== exp_pred(pc_i)) begin n_fail++; $display("FAIL rnd_predict_after[%0d]: got %b expected %b", i, predict_o, exp_pred(pc_i)); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) upd(32'h30, 1'b0, 1'b1);
    pc_i = 32'h30; #1;
    n_checks++; if (predict_o !== 1'b0) begin n_fail++; $display("FAIL pre_reset_predict: got %b expected 0", predict_o); end
    @(negedge clk_i);
    #2; rst_i = 1'b0;
    #1;
    model_reset();
    n_checks++; if (predict_o !== 1'b1) begin n_fail++; $display("FAIL async_reset_predict: got %b expected 1", predict_o); end
    n_checks++; if (branch_cnt_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_branch_cnt: got %0d expected 0", branch_cnt_o); end
    n_checks++; if (mispredict_cnt_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_misp_cnt: got %0d expected 0", mispredict_cnt_o); end
    n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_mispredict: got %b expected 0", mispredict_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    upd(32'h30, 1'b0, 1'b0);
    n_checks++; if (predict_o !== 1'b1 || branch_cnt_o !== 32'd1) begin n_fail++; $display("FAIL post_reset_update: got %b/%0d expected 1/1", predict_o, branch_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_train_not_taken();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
